// File: rtl/sram_arbiter.sv
// Two-port arbiter and bus sequencer for an 8-bit asynchronous SRAM.
// Port A has priority; port B is forced through after MAX_A_STREAK consecutive A grants.
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int MAX_A_STREAK  = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [20:0] a_addr,
    input  logic [7:0]  a_wdata,
    output logic [7:0]  a_rdata,
    output logic        a_ack,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [20:0] b_addr,
    input  logic [7:0]  b_wdata,
    output logic [7:0]  b_rdata,
    output logic        b_ack,

    output logic [20:0] sram_addr,
    input  logic [7:0]  sram_dq_i,
    output logic [7:0]  sram_dq_o,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        busy
);

    localparam logic [3:0] CNT_LAST   = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_A_STREAK);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_END
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [3:0]  streak_reg, streak_next;
    logic        gnt_b_reg, gnt_b_next;
    logic        op_we_reg, op_we_next;

    logic [20:0] sram_addr_reg, sram_addr_next;
    logic [7:0]  dq_o_reg, dq_o_next;
    logic        dq_oe_reg, dq_oe_next;
    logic        we_n_reg, we_n_next;
    logic        busy_reg, busy_next;

    // Per-port views, index 0 = A, index 1 = B
    logic        req_vec   [2];
    logic        we_vec    [2];
    logic [20:0] addr_vec  [2];
    logic [7:0]  wdata_vec [2];
    logic        ack_reg   [2];
    logic        ack_next  [2];
    logic [7:0]  rdata_reg [2];
    logic [7:0]  rdata_next[2];

    logic        pick_b;

    assign req_vec[0]   = a_req;
    assign req_vec[1]   = b_req;
    assign we_vec[0]    = a_we;
    assign we_vec[1]    = b_we;
    assign addr_vec[0]  = a_addr;
    assign addr_vec[1]  = b_addr;
    assign wdata_vec[0] = a_wdata;
    assign wdata_vec[1] = b_wdata;

    // B wins only when A is absent or A has used up its streak allowance
    assign pick_b = req_vec[1] && (!req_vec[0] || (streak_reg == STREAK_MAX));

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        streak_next    = streak_reg;
        gnt_b_next     = gnt_b_reg;
        op_we_next     = op_we_reg;
        sram_addr_next = sram_addr_reg;
        dq_o_next      = dq_o_reg;
        dq_oe_next     = 1'b0;
        we_n_next      = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ack_next[i]   = 1'b0;
            rdata_next[i] = rdata_reg[i];
        end

        case (state_reg)
            ST_IDLE: begin
                if (req_vec[0] || req_vec[1]) begin
                    gnt_b_next     = pick_b;
                    op_we_next     = we_vec[pick_b];
                    sram_addr_next = addr_vec[pick_b];
                    if (we_vec[pick_b]) begin
                        dq_o_next = wdata_vec[pick_b];
                    end
                    dq_oe_next = we_vec[pick_b];
                    cnt_next   = 4'd0;
                    state_next = ST_ACCESS;
                    if (!pick_b && req_vec[1]) begin
                        streak_next = (streak_reg == STREAK_MAX) ? streak_reg : streak_reg + 4'd1;
                    end else begin
                        streak_next = 4'd0;
                    end
                end
            end

            ST_ACCESS: begin
                dq_oe_next = op_we_reg;
                if (cnt_reg == CNT_LAST) begin
                    state_next          = ST_END;
                    ack_next[gnt_b_reg] = 1'b1;
                    if (!op_we_reg) begin
                        rdata_next[gnt_b_reg] = sram_dq_i;
                    end
                end else begin
                    // The cycle after this edge has cnt>=1, so the write strobe goes low
                    cnt_next  = cnt_reg + 4'd1;
                    we_n_next = ~op_we_reg;
                end
            end

            ST_END: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            streak_reg    <= 4'd0;
            gnt_b_reg     <= 1'b0;
            op_we_reg     <= 1'b0;
            sram_addr_reg <= 21'd0;
            dq_o_reg      <= 8'd0;
            dq_oe_reg     <= 1'b0;
            we_n_reg      <= 1'b1;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            streak_reg    <= streak_next;
            gnt_b_reg     <= gnt_b_next;
            op_we_reg     <= op_we_next;
            sram_addr_reg <= sram_addr_next;
            dq_o_reg      <= dq_o_next;
            dq_oe_reg     <= dq_oe_next;
            we_n_reg      <= we_n_next;
            busy_reg      <= busy_next;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        always_ff @(posedge clk) begin
            if (rst) begin
                ack_reg[gi]   <= 1'b0;
                rdata_reg[gi] <= 8'd0;
            end else begin
                ack_reg[gi]   <= ack_next[gi];
                rdata_reg[gi] <= rdata_next[gi];
            end
        end
    end

    assign a_ack      = ack_reg[0];
    assign b_ack      = ack_reg[1];
    assign a_rdata    = rdata_reg[0];
    assign b_rdata    = rdata_reg[1];
    assign sram_addr  = sram_addr_reg;
    assign sram_dq_o  = dq_o_reg;
    assign sram_dq_oe = dq_oe_reg;
    assign sram_we_n  = we_n_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default instance plus an ACCESS_CYCLES=4 instance.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [20:0] a_addr = 0, b_addr = 0;
    logic [7:0]  a_wdata = 0, b_wdata = 0;
    logic [7:0]  a_rdata, b_rdata;
    logic        a_ack, b_ack;
    logic [20:0] sram_addr;
    logic [7:0]  sram_dq_i = 0;
    logic [7:0]  sram_dq_o;
    logic        sram_dq_oe, sram_we_n, busy;

    logic        c_req = 0, c_we = 0, z_req = 0, z_we = 0;
    logic [20:0] c_addr = 0, z_addr = 0;
    logic [7:0]  c_wdata = 0, z_wdata = 0;
    logic [7:0]  c_rdata, z_rdata;
    logic        c_ack, z_ack;
    logic [20:0] s4_addr;
    logic [7:0]  s4_dq_i = 0;
    logic [7:0]  s4_dq_o;
    logic        s4_dq_oe, s4_we_n, busy4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ACCESS_CYCLES(2), .MAX_A_STREAK(4)) u_dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ack(b_ack),
        .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .busy(busy)
    );

    sram_arbiter #(.ACCESS_CYCLES(4), .MAX_A_STREAK(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .a_req(c_req), .a_we(c_we), .a_addr(c_addr), .a_wdata(c_wdata),
        .a_rdata(c_rdata), .a_ack(c_ack),
        .b_req(z_req), .b_we(z_we), .b_addr(z_addr), .b_wdata(z_wdata),
        .b_rdata(z_rdata), .b_ack(z_ack),
        .sram_addr(s4_addr), .sram_dq_i(s4_dq_i), .sram_dq_o(s4_dq_o),
        .sram_dq_oe(s4_dq_oe), .sram_we_n(s4_we_n), .busy(busy4)
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({sram_we_n, sram_dq_oe, busy, a_ack, b_ack} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_ctrl: got we_n/oe/busy/a_ack/b_ack=%b want 10000",
                     {sram_we_n, sram_dq_oe, busy, a_ack, b_ack});
        end
        total++;
        if ({sram_addr, sram_dq_o, a_rdata, b_rdata} !== 45'd0) begin
            bad++;
            $display("FAIL reset_data: got addr=%h dq_o=%h a_rdata=%h b_rdata=%h want all 0",
                     sram_addr, sram_dq_o, a_rdata, b_rdata);
        end
        total++;
        if ({s4_we_n, s4_dq_oe, busy4, c_ack} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_dut4: got we_n/oe/busy/ack=%b want 1000",
                     {s4_we_n, s4_dq_oe, busy4, c_ack});
        end
        rst = 1'b0;
        $display("reset: outputs checked");
    endtask

    // A write: addr valid from t+1, oe t+1..t+3, we_n low only at t+2, ack at t+3
    task automatic test_a_write();
        logic [4:0] exp_ctl [1:4];
        exp_ctl[1] = 5'b11100; // oe, we_n, busy, a_ack, b_ack
        exp_ctl[2] = 5'b10100;
        exp_ctl[3] = 5'b11110;
        exp_ctl[4] = 5'b01000;
        a_req = 1; a_we = 1; a_addr = 21'h1ABCD; a_wdata = 8'h5A;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if ({sram_dq_oe, sram_we_n, busy, a_ack, b_ack} !== exp_ctl[k]) begin
                bad++;
                $display("FAIL a_write_ctl t+%0d: got oe/we_n/busy/a_ack/b_ack=%b want %b",
                         k, {sram_dq_oe, sram_we_n, busy, a_ack, b_ack}, exp_ctl[k]);
            end
            if (k <= 3) begin
                total++;
                if (sram_addr !== 21'h1ABCD || sram_dq_o !== 8'h5A) begin
                    bad++;
                    $display("FAIL a_write_bus t+%0d: got addr=%h dq_o=%h want 1abcd 5a",
                             k, sram_addr, sram_dq_o);
                end
            end
            if (k == 3) a_req = 0;
        end
        $display("a_write: addr=1abcd data=5a done");
    endtask

    task automatic test_b_read();
        sram_dq_i = 8'hC3;
        b_req = 1; b_we = 0; b_addr = 21'h00100; b_wdata = 8'hFF;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            total++;
            if ({sram_dq_oe, sram_we_n} !== 2'b01 || sram_addr !== 21'h00100) begin
                bad++;
                $display("FAIL b_read_bus t+%0d: got oe=%b we_n=%b addr=%h want 0 1 00100",
                         k, sram_dq_oe, sram_we_n, sram_addr);
            end
            total++;
            if ({a_ack, b_ack} !== ((k == 3) ? 2'b01 : 2'b00)) begin
                bad++;
                $display("FAIL b_read_ack t+%0d: got a_ack=%b b_ack=%b", k, a_ack, b_ack);
            end
        end
        total++;
        if (b_rdata !== 8'hC3 || a_rdata !== 8'h00) begin
            bad++;
            $display("FAIL b_read_data: got b_rdata=%h a_rdata=%h want c3 00", b_rdata, a_rdata);
        end
        b_req = 0;
        @(negedge clk);
        $display("b_read: addr=00100 rdata=%h", b_rdata);
    endtask

    task automatic test_simultaneous();
        sram_dq_i = 8'h3C;
        a_req = 1; a_we = 1; a_addr = 21'h00055; a_wdata = 8'h11;
        b_req = 1; b_we = 0; b_addr = 21'h1FFFFF;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++;
            if (a_ack !== (k == 3) || b_ack !== (k == 7)) begin
                bad++;
                $display("FAIL simul_ack t+%0d: got a_ack=%b b_ack=%b", k, a_ack, b_ack);
            end
            if (k == 4) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL simul_idle: got busy=%b want 0", busy);
                end
            end
            if (k == 5) begin
                total++;
                if (sram_addr !== 21'h1FFFFF || sram_dq_oe !== 1'b0) begin
                    bad++;
                    $display("FAIL simul_b_addr: got addr=%h oe=%b want 1fffff 0", sram_addr, sram_dq_oe);
                end
            end
            if (k == 7) begin
                total++;
                if (b_rdata !== 8'h3C) begin
                    bad++;
                    $display("FAIL simul_b_rdata: got %h want 3c", b_rdata);
                end
                b_req = 0;
            end
            if (k == 3) a_req = 0;
        end
        $display("simultaneous: A then B, gap 4 cycles");
    endtask

    task automatic test_streak();
        int exp_port [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int got_port [10];
        int got_cyc  [10];
        int n = 0;
        a_req = 1; a_we = 1; a_addr = 21'h00AAA; a_wdata = 8'h77;
        b_req = 1; b_we = 0; b_addr = 21'h00BBB;
        for (int cyc = 1; cyc <= 80 && n < 10; cyc++) begin
            @(negedge clk);
            if (a_ack && b_ack) begin
                total++; bad++;
                $display("FAIL streak_both_ack: cycle %0d", cyc);
            end
            if (a_ack || b_ack) begin
                got_port[n] = b_ack ? 1 : 0;
                got_cyc[n]  = cyc;
                n++;
                if (n == 10) begin
                    a_req = 0;
                    b_req = 0;
                end
            end
        end
        total++;
        if (n != 10) begin
            bad++;
            $display("FAIL streak_timeout: got %0d acks want 10", n);
        end
        for (int i = 0; i < n; i++) begin
            total++;
            if (got_port[i] != exp_port[i]) begin
                bad++;
                $display("FAIL streak_order[%0d]: got port %0d want %0d", i, got_port[i], exp_port[i]);
            end
            if (i > 0) begin
                total++;
                if (got_cyc[i] - got_cyc[i-1] != 4) begin
                    bad++;
                    $display("FAIL streak_spacing[%0d]: got %0d cycles want 4", i, got_cyc[i] - got_cyc[i-1]);
                end
            end
            $display("streak: ack %0d port=%s cycle=%0d", i, got_port[i] ? "B" : "A", got_cyc[i]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        a_req = 1; a_we = 1; a_addr = 21'h00321; a_wdata = 8'hA5;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (sram_we_n !== 1'b0) begin
            bad++;
            $display("FAIL midrst_strobe: got we_n=%b want 0", sram_we_n);
        end
        rst = 1; a_req = 0;
        @(negedge clk);
        rst = 0;
        total++;
        if ({sram_we_n, sram_dq_oe, busy, a_ack, b_ack} !== 5'b10000 || b_rdata !== 8'h00) begin
            bad++;
            $display("FAIL midrst_abort: got we_n/oe/busy/a_ack/b_ack=%b b_rdata=%h want 10000 00",
                     {sram_we_n, sram_dq_oe, busy, a_ack, b_ack}, b_rdata);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (a_ack !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL midrst_quiet: got a_ack=%b busy=%b want 0 0", a_ack, busy);
            end
        end
        sram_dq_i = 8'h99;
        a_req = 1; a_we = 0; a_addr = 21'h0ABCD;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            total++;
            if (a_ack !== (k == 3)) begin
                bad++;
                $display("FAIL midrst_new_ack t+%0d: got a_ack=%b", k, a_ack);
            end
        end
        total++;
        if (a_rdata !== 8'h99) begin
            bad++;
            $display("FAIL midrst_new_rdata: got %h want 99", a_rdata);
        end
        a_req = 0;
        @(negedge clk);
        $display("reset_mid_write: aborted, follow-up read rdata=%h", a_rdata);
    endtask

    task automatic test_long_access();
        logic exp_we_n [1:6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int   low_cnt = 0;
        c_req = 1; c_we = 1; c_addr = 21'h12345; c_wdata = 8'hE7;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (s4_we_n === 1'b0) low_cnt++;
            total++;
            if (s4_we_n !== exp_we_n[k] || s4_dq_oe !== (k <= 5) || c_ack !== (k == 5)) begin
                bad++;
                $display("FAIL long_ctl t+%0d: got we_n=%b oe=%b ack=%b", k, s4_we_n, s4_dq_oe, c_ack);
            end
            if (k == 5) begin
                total++;
                if (s4_dq_o !== 8'hE7 || s4_addr !== 21'h12345) begin
                    bad++;
                    $display("FAIL long_hold: got dq_o=%h addr=%h want e7 12345", s4_dq_o, s4_addr);
                end
                c_req = 0;
            end
        end
        total++;
        if (low_cnt != 3) begin
            bad++;
            $display("FAIL long_we_width: got %0d low cycles want 3", low_cnt);
        end
        $display("long_access: we_n low %0d cycles", low_cnt);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_a_write();
        test_b_read();
        test_simultaneous();
        test_streak();
        test_reset_mid_write();
        test_long_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Arbitrates the single external 8-bit asynchronous SRAM (21-bit address, active-low WE) between two requesters.
- Port A is the high-priority, latency-sensitive requester (video/ULA fetch). Port B is the bulk requester (CPU/DMA).
- Sequences the SRAM bus timing: address setup, WE pulse, data hold and read sampling.
- Sits between the core logic and the top-level SRAM pins. The top level merges sram_dq_o/sram_dq_oe into the inout data bus.

Parameters:
- ACCESS_CYCLES, 2, clocks spent in ACCESS per transfer; legal range 2..15 (2 = 71 ns at 28 MHz).
- MAX_A_STREAK, 4, consecutive port-A grants allowed while B is pending before B is forced; legal range 1..15.

Ports:
- clk  in  1  system clock (28 MHz).
- rst  in  1  synchronous reset, active-high.
- a_req  in  1  port A request, level; held with command stable until a_ack.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  21  port A address.
- a_wdata  in  8  port A write data.
- a_rdata  out  8  port A read data; valid while a_ack=1, held until A's next read completes.
- a_ack  out  1  port A one-cycle completion pulse.
- b_req, b_we, b_addr, b_wdata, b_rdata, b_ack: same set of signals and rules for port B.
- sram_addr  out  21  SRAM address, registered.
- sram_dq_i  in  8  SRAM data from pins.
- sram_dq_o  out  8  SRAM data to pins.
- sram_dq_oe  out  1  1 = drive data bus.
- sram_we_n  out  1  SRAM write enable, active-low.
- busy  out  1  1 when state is not IDLE.

Behaviour:

Outputs and reset:
- All outputs are registered.
- On rst, at the next edge: state=IDLE, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0, a_ack=b_ack=0, a_rdata=b_rdata=0, streak=0.
- Reset mid-transfer aborts the access. No ack is produced and no rdata is updated.

States: IDLE, ACCESS, END.

IDLE:
- Grant when any req=1. A wins unless b_req=1 and streak==MAX_A_STREAK, in which case B wins.
- On grant: latch the port's addr/we/wdata; sram_addr<=addr; cnt<=0; go to ACCESS.
- No req: stay in IDLE; outputs idle (we_n=1, oe=0).

ACCESS (cnt 0..ACCESS_CYCLES-1):
- sram_addr stable throughout.
- Write: sram_dq_oe=1 and sram_dq_o=wdata for all ACCESS cycles. sram_we_n=1 at cnt=0 (address setup), 0 for cnt=1..ACCESS_CYCLES-1.
- Read: oe=0, we_n=1 throughout. On the edge ending cnt=ACCESS_CYCLES-1, the granted port's rdata<=sram_dq_i.
- After cnt=ACCESS_CYCLES-1, go to END.

END (1 cycle):
- sram_we_n=1. For a write, oe=1 and data held (hold time); for a read, oe=0.
- sram_addr held.
- Granted port's ack=1 (this applies to both reads and writes).
- Next state is always IDLE.

Latency and throughput:
- Request sampled in IDLE at cycle t gives ack at cycle t+ACCESS_CYCLES+1.
- Throughput is one transfer per ACCESS_CYCLES+2 cycles.
- A requester may change its command the cycle after ack. A req still high the cycle after ack is a new request.

Streak counter:
- On a grant to A with b_req=1: streak<=streak+1, saturating at MAX_A_STREAK.
- On a grant to B, or any grant with b_req=0: streak<=0.

Other rules:
- A request deasserted before its ack is a protocol violation; behaviour is undefined.
- Requests are not sampled outside IDLE. A request arriving during ACCESS/END waits.
- Simultaneous a_req and b_req with streak<MAX: A is served, then B on the next IDLE if A is idle or streak has reached MAX.
- Address wrap: no arithmetic is performed on the address; all 21 bits are passed through.
- Invariant: sram_we_n=0 only when sram_dq_oe=1 and state=ACCESS with cnt>=1.

Test Plan:
1. ACCESS_CYCLES=2, A write addr 0x1ABCD data 0x5A, req at cycle t -> sram_addr=0x1ABCD from t+1; oe=1 t+1..t+3; we_n=0 only at t+2; a_ack pulse at t+3; b_ack stays 0.
2. B read addr 0x00100, SRAM model returns 0xC3 -> b_rdata=0xC3 while b_ack=1 at t+3; we_n stays 1; oe stays 0 throughout.
3. a_req and b_req raised in the same cycle (streak=0) -> A transfer acked first; B granted in the following IDLE; b_ack 4 cycles after a_ack.
4. MAX_A_STREAK=4, A re-requests continuously, B pending -> grant sequence A,A,A,A,B,A...; streak returns to 0 after the B grant.
5. rst asserted while we_n=0 -> next cycle we_n=1, oe=0, busy=0, no ack; a new request after rst completes normally.
6. ACCESS_CYCLES=4 write -> we_n low exactly 3 consecutive cycles; ack at t+5; data held on sram_dq_o through the END cycle.
